// File: rtl/mem_request_queue.sv
// Request FIFO and single-outstanding sequencer in front of the RAM/ROM controller.
// A watchdog retires requests that the controller never acknowledges.
//
// state    | meaning
// IDLE     | wait for a queued request and ctl_ready, then load and pop the head
// ISSUE    | ctl_start pulse, watchdog armed
// WAIT_ACK | wait for ctl_ack or watchdog expiry, then retire
module mem_request_queue #(
    parameter int ADDRESS_SIZE = 24,
    parameter int DATA_SIZE    = 16,
    parameter int DEPTH_LOG2   = 2,
    parameter int TIMEOUT      = 255
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic [ADDRESS_SIZE-1:0] req_addr,
    input  logic [DATA_SIZE-1:0]    req_data,
    input  logic                    req_chip,
    input  logic                    req_length,
    input  logic                    req_op,
    output logic                    rsp_valid,
    output logic [DATA_SIZE-1:0]    rsp_data,
    output logic                    rsp_err,
    output logic                    ctl_start,
    output logic [ADDRESS_SIZE-1:0] ctl_addr,
    output logic [DATA_SIZE-1:0]    ctl_data,
    output logic                    ctl_chip,
    output logic                    ctl_length,
    output logic                    ctl_op,
    input  logic                    ctl_ready,
    input  logic                    ctl_ack,
    input  logic [DATA_SIZE-1:0]    ctl_rdata,
    output logic [DEPTH_LOG2:0]     fifo_count,
    output logic                    busy
);
    localparam int DEPTH   = 1 << DEPTH_LOG2;
    localparam int ENTRY_W = ADDRESS_SIZE + DATA_SIZE + 3;
    localparam logic [DEPTH_LOG2:0] FULL_COUNT = (DEPTH_LOG2 + 1)'(DEPTH);

    localparam logic [1:0] S_IDLE     = 2'd0;
    localparam logic [1:0] S_ISSUE    = 2'd1;
    localparam logic [1:0] S_WAIT_ACK = 2'd2;

    logic [ENTRY_W-1:0]      mem_q [DEPTH];
    logic [ENTRY_W-1:0]      mem_d [DEPTH];
    logic [DEPTH_LOG2-1:0]   wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2-1:0]   rd_ptr_q, rd_ptr_d;
    logic [DEPTH_LOG2:0]     count_q, count_d;
    logic [1:0]              state_q, state_d;
    logic [7:0]              wd_q, wd_d;
    logic [ENTRY_W-1:0]      ctl_entry_q, ctl_entry_d;
    logic                    ctl_start_q, ctl_start_d;
    logic                    rsp_valid_q, rsp_valid_d;
    logic [DATA_SIZE-1:0]    rsp_data_q, rsp_data_d;
    logic                    rsp_err_q, rsp_err_d;
    logic                    push;
    logic                    load;

    assign req_ready = (count_q != FULL_COUNT) && !rst;
    assign push      = req_valid && req_ready;
    // The retire cycle is spent in IDLE without loading, so back-to-back
    // requests are spaced at least four cycles apart.
    assign load      = (state_q == S_IDLE) && (count_q != '0) && ctl_ready && !rsp_valid_q;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            mem_d[wr_ptr_q] = {req_addr, req_data, req_chip, req_length, req_op};
            wr_ptr_d        = wr_ptr_q + DEPTH_LOG2'(1);
        end
        if (load) begin
            rd_ptr_d = rd_ptr_q + DEPTH_LOG2'(1);
        end
        case ({push, load})
            2'b10:   count_d = count_q + (DEPTH_LOG2 + 1)'(1);
            2'b01:   count_d = count_q - (DEPTH_LOG2 + 1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        wd_d        = wd_q;
        ctl_entry_d = ctl_entry_q;
        ctl_start_d = 1'b0;
        rsp_valid_d = 1'b0;
        rsp_data_d  = '0;
        rsp_err_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (load) begin
                    ctl_entry_d = mem_q[rd_ptr_q];
                    ctl_start_d = 1'b1;
                    state_d     = S_ISSUE;
                end
            end
            S_ISSUE: begin
                // Down-counter reaching zero marks the TIMEOUT-th WAIT_ACK cycle.
                wd_d    = 8'(TIMEOUT - 1);
                state_d = S_WAIT_ACK;
            end
            S_WAIT_ACK: begin
                if (ctl_ack) begin
                    rsp_valid_d = 1'b1;
                    rsp_data_d  = ctl_entry_q[0] ? '0 : ctl_rdata;
                    state_d     = S_IDLE;
                end else if (wd_q == 8'd0) begin
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b1;
                    state_d     = S_IDLE;
                end else begin
                    wd_d = wd_q - 8'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            state_q     <= S_IDLE;
            wd_q        <= '0;
            ctl_entry_q <= '0;
            ctl_start_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            state_q     <= state_d;
            wd_q        <= wd_d;
            ctl_entry_q <= ctl_entry_d;
            ctl_start_q <= ctl_start_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    assign {ctl_addr, ctl_data, ctl_chip, ctl_length, ctl_op} = ctl_entry_q;
    assign ctl_start  = ctl_start_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_data   = rsp_data_q;
    assign rsp_err    = rsp_err_q;
    assign fifo_count = count_q;
    assign busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_mem_request_queue.sv
// Bench for mem_request_queue: directed phases plus random streaming, checked
// against a transaction-level model (request queue, in-flight request, ack schedule).
module tb_mem_request_queue;
    localparam int TO = 8;

    typedef struct packed {
        logic [23:0] addr;
        logic [15:0] data;
        logic        chip;
        logic        length;
        logic        op;
    } req_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [23:0] req_addr;
    logic [15:0] req_data;
    logic        req_chip, req_length, req_op;
    logic        rsp_valid;
    logic [15:0] rsp_data;
    logic        rsp_err;
    logic        ctl_start;
    logic [23:0] ctl_addr;
    logic [15:0] ctl_data;
    logic        ctl_chip, ctl_length, ctl_op;
    logic        ctl_ready;
    logic        ctl_ack;
    logic [15:0] ctl_rdata;
    logic [2:0]  fifo_count;
    logic        busy;

    req_t drv;
    assign {req_addr, req_data, req_chip, req_length, req_op} = drv;

    always #5 clk = ~clk;

    mem_request_queue #(.ADDRESS_SIZE(24), .DATA_SIZE(16), .DEPTH_LOG2(2), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_addr(req_addr), .req_data(req_data), .req_chip(req_chip),
        .req_length(req_length), .req_op(req_op),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err),
        .ctl_start(ctl_start), .ctl_addr(ctl_addr), .ctl_data(ctl_data),
        .ctl_chip(ctl_chip), .ctl_length(ctl_length), .ctl_op(ctl_op),
        .ctl_ready(ctl_ready), .ctl_ack(ctl_ack), .ctl_rdata(ctl_rdata),
        .fifo_count(fifo_count), .busy(busy)
    );

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    req_t        model_q[$];
    logic [23:0] issued_q[$];
    req_t        cur = '0;
    bit          inflight = 0;
    int          start_cyc = -1000;
    int          ack_cyc = -1000;
    int          last_rsp_cyc = -1000;
    logic [15:0] ack_dat = '0;
    int          ack_lat = 1;
    bit          rand_ack = 0;
    bit          fix_en = 0;
    logic [15:0] fix_val = '0;
    bit          last_push = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic req_t mk(input logic [23:0] a, input logic [15:0] d,
                                input logic c, input logic l, input logic o);
        req_t r;
        r.addr = a; r.data = d; r.chip = c; r.length = l; r.op = o;
        return r;
    endfunction

    function automatic req_t rnd_req();
        return mk(24'($urandom), 16'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
    endfunction

    task automatic observe(input bit was_rst);
        int  lat;
        bit  acked, timed;
        if (ctl_start === 1'b1) begin
            chk("start_while_busy", inflight, 0);
            chk("start_spacing", (cyc - last_rsp_cyc) >= 2, 1);
            chk("start_has_entry", model_q.size() != 0, 1);
            if (model_q.size() != 0) cur = model_q.pop_front();
            issued_q.push_back(cur.addr);
            if (rand_ack) begin
                case ($urandom_range(0, 4))
                    0: lat = 0;
                    1: lat = 1;
                    2: lat = 2;
                    3: lat = 3;
                    default: lat = TO;
                endcase
            end else begin
                lat = ack_lat;
            end
            inflight  = 1;
            start_cyc = cyc;
            ack_cyc   = (lat == 0) ? -1000 : cyc + lat;
            ack_dat   = fix_en ? fix_val : 16'($urandom);
        end
        acked = inflight && (cyc - 1 == ack_cyc);
        timed = inflight && !acked && (cyc - 1 == start_cyc + TO);
        chk("rsp_valid", rsp_valid, acked || timed);
        if (acked || timed) begin
            chk("rsp_err", rsp_err, timed);
            chk("rsp_data", rsp_data, (timed || cur.op) ? 16'h0 : ack_dat);
            inflight     = 0;
            last_rsp_cyc = cyc;
        end
        chk("req_ready", req_ready, !rst && (model_q.size() < 4));
        chk("fifo_count", fifo_count, model_q.size());
        chk("busy", busy, inflight);
        chk("ctl_fields", {ctl_addr, ctl_data, ctl_chip, ctl_length, ctl_op}, cur);
        if (was_rst) begin
            chk("rst_ctl_start", ctl_start, 0);
            chk("rst_rsp_data", rsp_data, 0);
            chk("rst_rsp_err", rsp_err, 0);
        end
    endtask

    task automatic tick();
        bit pushing, was_rst;
        ctl_ack   = inflight && (cyc == ack_cyc);
        ctl_rdata = ctl_ack ? ack_dat : 16'($urandom);
        pushing   = req_valid && !rst && (model_q.size() < 4);
        was_rst   = rst;
        @(posedge clk);
        #1;
        cyc++;
        last_push = 0;
        if (was_rst) begin
            model_q.delete();
            inflight     = 0;
            cur          = '0;
            last_rsp_cyc = -1000;
        end else if (pushing) begin
            model_q.push_back(drv);
            last_push = 1;
        end
        observe(was_rst);
    endtask

    task automatic wait_idle(input int max);
        int n = 0;
        while ((model_q.size() != 0 || inflight) && n < max) begin
            tick();
            n++;
        end
        chk("wait_idle_bound", (model_q.size() == 0) && !inflight, 1);
    endtask

    task automatic wait_start(input int max);
        int n = 0;
        while (!inflight && n < max) begin
            tick();
            n++;
        end
        chk("wait_start_bound", inflight, 1);
    endtask

    initial begin
        int c1, s, n;
        rst = 1; req_valid = 0; ctl_ready = 0; ctl_ack = 0; ctl_rdata = '0;
        drv = '0;

        // reset state
        repeat (3) tick();
        rst = 0;
        tick();

        // single read with a 2-cycle ack
        ctl_ready = 1; ack_lat = 2; fix_en = 1; fix_val = 16'hBEEF; rand_ack = 0;
        drv = mk(24'h000123, 16'h5555, 1'b1, 1'b1, 1'b0);
        req_valid = 1;
        tick();
        req_valid = 0;
        c1 = cyc;
        chk("single_count1", fifo_count, 1);
        tick();
        chk("single_start", ctl_start, 1);
        chk("single_ctl_addr", ctl_addr, 24'h000123);
        tick();
        chk("single_start_pulse", ctl_start, 0);
        wait_idle(20);
        chk("single_rsp_cycle", last_rsp_cyc, c1 + 4);
        fix_en = 0;

        // fill with ctl_ready low, then drain in push order
        issued_q.delete();
        ctl_ready = 0; ack_lat = 1;
        for (int i = 0; i < 4; i++) begin
            drv = mk(24'h000100 + 24'(i), 16'($urandom), 1'b0, 1'b1, 1'b1);
            req_valid = 1;
            tick();
        end
        chk("fill_count", fifo_count, 4);
        chk("fill_ready_low", req_ready, 0);
        drv = mk(24'h000104, 16'($urandom), 1'b0, 1'b1, 1'b1);
        tick();
        tick();
        chk("fill_count_held", fifo_count, 4);
        ctl_ready = 1;
        n = 0;
        while (!last_push && n < 40) begin
            tick();
            n++;
        end
        chk("fill_5th_accepted", last_push, 1);
        req_valid = 0;
        wait_idle(60);
        chk("fill_issued_n", issued_q.size(), 5);
        for (int i = 0; i < 5 && i < issued_q.size(); i++)
            chk("fill_order", issued_q[i], 24'h000100 + 24'(i));

        // random streaming with wrap, mixed acks and timeouts
        issued_q.delete();
        rand_ack = 1;
        for (int i = 0; i < 400; i++) begin
            ctl_ready = ($urandom_range(0, 3) != 0);
            req_valid = 1'($urandom);
            drv = rnd_req();
            tick();
        end
        req_valid = 0; ctl_ready = 1;
        wait_idle(300);
        chk("wrap_issued_enough", issued_q.size() >= 10, 1);
        rand_ack = 0;

        // timeout without ack
        ack_lat = 0;
        drv = mk(24'h00ABCD, 16'h1234, 1'b1, 1'b0, 1'b0);
        req_valid = 1;
        tick();
        req_valid = 0;
        wait_start(10);
        s = start_cyc;
        wait_idle(20);
        chk("timeout_rsp_cycle", last_rsp_cyc, s + TO + 1);

        // ack in the final watchdog cycle wins
        ack_lat = TO;
        drv = mk(24'h00DCBA, 16'h4321, 1'b0, 1'b0, 1'b0);
        req_valid = 1;
        tick();
        req_valid = 0;
        wait_start(10);
        s = start_cyc;
        wait_idle(20);
        chk("late_ack_rsp_cycle", last_rsp_cyc, s + TO + 1);

        // reset in WAIT_ACK with requests queued
        ctl_ready = 0; ack_lat = 0;
        for (int i = 0; i < 3; i++) begin
            drv = rnd_req();
            req_valid = 1;
            tick();
        end
        req_valid = 0;
        ctl_ready = 1;
        wait_start(10);
        tick();
        tick();
        chk("pre_rst_busy", busy, 1);
        rst = 1;
        tick();
        chk("rst_count", fifo_count, 0);
        chk("rst_ready_low", req_ready, 0);
        rst = 0;
        tick();
        chk("post_rst_ready", req_ready, 1);
        repeat (12) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
